// File: rtl/ascon_sbox_lut_pkg.sv
// Shared types, the ASCON 5-bit S-box constant and the bank reset-table helper.
// No ports: imported by the bank, interface users and the engine top.
package ascon_sbox_lut_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [4:0] ASCON_SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    // Reset content of entry idx for a table of width w:
    // the ASCON S-box for 5-bit lanes, identity otherwise.
    function automatic logic [31:0] default_table(input int w, input int idx);
        if (w == 5) begin
            return 32'(ASCON_SBOX[idx[4:0]]);
        end
        return 32'(idx);
    endfunction

endpackage

// File: rtl/ascon_sbox_lut_engine_if.sv
// Block stream (valid/ready in and out) plus table config bus of the engine.
// slave: engine side; master: producer/consumer/software side.
interface ascon_sbox_lut_engine_if #(
    parameter int SBOX_W = 5,
    parameter int LANES  = 64
);
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [LANES*SBOX_W-1:0]   in_data_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [LANES*SBOX_W-1:0]   out_data_o;
    logic                      cfg_we_i;
    logic [SBOX_W-1:0]         cfg_addr_i;
    logic [SBOX_W-1:0]         cfg_wdata_i;
    logic [SBOX_W-1:0]         cfg_rdata_o;
    logic                      cfg_commit_i;
    logic                      cfg_ready_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        input  cfg_we_i, cfg_addr_i, cfg_wdata_i, cfg_commit_i,
        output in_ready_o, out_valid_o, out_data_o,
        output cfg_rdata_o, cfg_ready_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        output cfg_we_i, cfg_addr_i, cfg_wdata_i, cfg_commit_i,
        input  in_ready_o, out_valid_o, out_data_o,
        input  cfg_rdata_o, cfg_ready_o
    );
endinterface

// File: rtl/ascon_sbox_lut_bank.sv
// One 2**SBOX_W x SBOX_W flop table: sync write, NRD combinational reads.
// Ports: clk_i, rst_i (reload default), i_we/i_waddr/i_wdata, i_raddr -> o_rdata.
module ascon_sbox_lut_bank
    import ascon_sbox_lut_pkg::*;
#(
    parameter int SBOX_W = 5,
    parameter int NRD    = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_we,
    input  logic [SBOX_W-1:0]     i_waddr,
    input  logic [SBOX_W-1:0]     i_wdata,
    input  logic [NRD*SBOX_W-1:0] i_raddr,
    output logic [NRD*SBOX_W-1:0] o_rdata
);
    localparam int DEPTH = 1 << SBOX_W;

    logic [SBOX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= SBOX_W'(default_table(SBOX_W, i));
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int p = 0; p < NRD; p++) begin
            o_rdata[p*SBOX_W +: SBOX_W] = r_mem[i_raddr[p*SBOX_W +: SBOX_W]];
        end
    end

endmodule

// File: rtl/ascon_sbox_lut_engine.sv
// Double-buffered S-box engine: PORTS lanes per beat, NBEATS beats per block.
// Ports: clk_i, rst_i (sync, high), io_bus (slave: stream + table config).
module ascon_sbox_lut_engine
    import ascon_sbox_lut_pkg::*;
#(
    parameter int SBOX_W = 5,
    parameter int LANES  = 64,
    parameter int PORTS  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    ascon_sbox_lut_engine_if.slave   io_bus
);
    localparam int NBEATS = LANES / PORTS;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int DW     = LANES * SBOX_W;
    localparam int PW     = PORTS * SBOX_W;
    localparam int RW     = (PORTS + 1) * SBOX_W;

    if ((LANES % PORTS) != 0) begin : g_bad_ports
        $error("LANES must be a multiple of PORTS");
    end

    state_e            r_state;
    logic [BW-1:0]     r_beat;
    logic [DW-1:0]     r_in;
    logic [DW-1:0]     r_out;
    logic              r_active;
    logic              r_pend;
    logic              r_iready;
    logic              r_oval;
    logic [SBOX_W-1:0] r_rdata;

    logic              w_wacc;
    logic              w_swap;
    logic              w_last;
    logic [RW-1:0]     w_raddr;
    logic [RW-1:0]     w_rd0;
    logic [RW-1:0]     w_rd1;
    logic [PW-1:0]     w_sub;
    logic [SBOX_W-1:0] w_sh_rd;
    logic [SBOX_W-1:0] w_act_rd;

    assign w_wacc = io_bus.cfg_we_i && !r_pend;
    // Swap only between blocks so a block never mixes two tables.
    assign w_swap = (r_state == IDLE) && (r_pend || io_bus.cfg_commit_i);
    assign w_last = (r_beat == BW'(NBEATS - 1));

    // Ports 0..PORTS-1 serve the current beat; the last port serves readback.
    always_comb begin
        w_raddr = '0;
        for (int p = 0; p < PORTS; p++) begin
            w_raddr[p*SBOX_W +: SBOX_W] =
                r_in[(int'(r_beat) * PORTS + p) * SBOX_W +: SBOX_W];
        end
        w_raddr[PORTS*SBOX_W +: SBOX_W] = io_bus.cfg_addr_i;
    end

    always_comb begin
        w_sub = '0;
        for (int p = 0; p < PORTS; p++) begin
            w_sub[p*SBOX_W +: SBOX_W] = r_active ?
                w_rd1[p*SBOX_W +: SBOX_W] : w_rd0[p*SBOX_W +: SBOX_W];
        end
    end

    assign w_sh_rd  = r_active ? w_rd0[PORTS*SBOX_W +: SBOX_W]
                               : w_rd1[PORTS*SBOX_W +: SBOX_W];
    assign w_act_rd = r_active ? w_rd1[PORTS*SBOX_W +: SBOX_W]
                               : w_rd0[PORTS*SBOX_W +: SBOX_W];

    ascon_sbox_lut_bank #(.SBOX_W(SBOX_W), .NRD(PORTS + 1)) u_bank0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_we    (w_wacc && r_active),
        .i_waddr (io_bus.cfg_addr_i),
        .i_wdata (io_bus.cfg_wdata_i),
        .i_raddr (w_raddr),
        .o_rdata (w_rd0)
    );

    ascon_sbox_lut_bank #(.SBOX_W(SBOX_W), .NRD(PORTS + 1)) u_bank1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_we    (w_wacc && !r_active),
        .i_waddr (io_bus.cfg_addr_i),
        .i_wdata (io_bus.cfg_wdata_i),
        .i_raddr (w_raddr),
        .o_rdata (w_rd1)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_in     <= '0;
            r_out    <= '0;
            r_active <= 1'b0;
            r_pend   <= 1'b0;
            r_iready <= 1'b1;
            r_oval   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_active <= r_active ^ w_swap;
            r_pend   <= !w_swap && (r_pend || io_bus.cfg_commit_i);
            // Readback shows the shadow as it stands after this edge:
            // after a swap that is the old active bank.
            if (w_swap) begin
                r_rdata <= w_act_rd;
            end else if (w_wacc) begin
                r_rdata <= io_bus.cfg_wdata_i;
            end else begin
                r_rdata <= w_sh_rd;
            end
            unique case (r_state)
                IDLE: begin
                    if (io_bus.in_valid_i) begin
                        r_in     <= io_bus.in_data_i;
                        r_beat   <= '0;
                        r_state  <= RUN;
                        r_iready <= 1'b0;
                    end
                end
                RUN: begin
                    r_out[int'(r_beat) * PW +: PW] <= w_sub;
                    if (w_last) begin
                        r_beat  <= '0;
                        r_state <= DONE;
                        r_oval  <= 1'b1;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                DONE: begin
                    if (io_bus.out_ready_i) begin
                        r_state  <= IDLE;
                        r_oval   <= 1'b0;
                        r_iready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.in_ready_o  = r_iready;
    assign io_bus.out_valid_o = r_oval;
    assign io_bus.out_data_o  = r_out;
    assign io_bus.cfg_rdata_o = r_rdata;
    assign io_bus.cfg_ready_o = !r_pend;

endmodule

// File: tb/tb_ascon_sbox_lut_engine.sv
// Directed + random bench for ascon_sbox_lut_engine against an
// active/shadow table model with swap-on-commit.
module tb_ascon_sbox_lut_engine;

    localparam int W  = 5;
    localparam int L  = 64;
    localparam int P  = 16;
    localparam int DW = L * W;
    localparam int NB = L / P;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ascon_sbox_lut_engine_if #(.SBOX_W(W), .LANES(L)) bus ();

    ascon_sbox_lut_engine #(.SBOX_W(W), .LANES(L), .PORTS(P)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .io_bus (bus)
    );

    int ncmp = 0;
    int nerr = 0;

    int sbox [32] = '{
        'h04, 'h0b, 'h1f, 'h14, 'h1a, 'h15, 'h09, 'h02,
        'h1b, 'h05, 'h08, 'h12, 'h1d, 'h03, 'h06, 'h1c,
        'h1e, 'h13, 'h07, 'h0e, 'h00, 'h0d, 'h11, 'h18,
        'h10, 'h0c, 'h01, 'h19, 'h16, 'h0a, 'h0f, 'h17
    };
    int m_act [32];
    int m_sh  [32];

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_act[i] = sbox[i];
            m_sh[i]  = sbox[i];
        end
    endtask

    task automatic m_swap();
        int t;
        for (int i = 0; i < 32; i++) begin
            t        = m_act[i];
            m_act[i] = m_sh[i];
            m_sh[i]  = t;
        end
    endtask

    function automatic logic [DW-1:0] expect_of(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < L; i++) begin
            r[i*W +: W] = W'(m_act[d[i*W +: W]]);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_block();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) begin
            d[k*32 +: 32] = $urandom();
        end
        return d;
    endfunction

    task automatic cfg_write(input int a, input int v);
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = W'(a);
        bus.cfg_wdata_i = W'(v);
        step();
        bus.cfg_we_i    = 1'b0;
        m_sh[a]         = v;
    endtask

    task automatic cfg_read(input string tag, input int a);
        bus.cfg_addr_i = W'(a);
        step();
        chk(tag, DW'(bus.cfg_rdata_o), DW'(m_sh[a]));
    endtask

    task automatic send(input string tag, input logic [DW-1:0] d);
        chk({tag, "_rdy"}, DW'(bus.in_ready_o), DW'(1));
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        step();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int lat0,
                            input logic [DW-1:0] exp, input int hold);
        int lat;
        lat = lat0;
        while (!bus.out_valid_o && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, DW'(lat), DW'(NB));
        chk({tag, "_data"}, bus.out_data_o, exp);
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, "_hold_v"}, DW'(bus.out_valid_o), DW'(1));
            chk({tag, "_hold_d"}, bus.out_data_o, exp);
        end
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;
        chk({tag, "_drop_v"}, DW'(bus.out_valid_o), DW'(0));
        chk({tag, "_idle_d"}, bus.out_data_o, exp);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        logic [DW-1:0] k04;
        logic [DW-1:0] k1f;

        bus.in_valid_i   = 1'b0;
        bus.in_data_i    = '0;
        bus.out_ready_i  = 1'b0;
        bus.cfg_we_i     = 1'b0;
        bus.cfg_addr_i   = '0;
        bus.cfg_wdata_i  = '0;
        bus.cfg_commit_i = 1'b0;
        for (int i = 0; i < L; i++) begin
            k04[i*W +: W] = 5'h04;
            k1f[i*W +: W] = 5'h1f;
        end

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_reset();

        chk("rst_oval", DW'(bus.out_valid_o), DW'(0));
        chk("rst_odata", bus.out_data_o, '0);
        chk("rst_rdata", DW'(bus.cfg_rdata_o), DW'(0));
        chk("rst_cfgrdy", DW'(bus.cfg_ready_o), DW'(1));
        chk("rst_irdy", DW'(bus.in_ready_o), DW'(1));

        send("t1", '0);
        wait_out("t1", 0, k04, 0);

        for (int i = 0; i < L; i++) begin
            d[i*W +: W] = (i % 3 == 0) ? 5'h00 : (i % 3 == 1) ? 5'h01 : 5'h1f;
            e[i*W +: W] = (i % 3 == 0) ? 5'h04 : (i % 3 == 1) ? 5'h0b : 5'h17;
        end
        send("t2", d);
        wait_out("t2", 0, e, 5);

        for (int r = 0; r < 3; r++) begin
            d = rand_block();
            send("rnd", d);
            wait_out("rnd", 0, expect_of(d), r);
        end

        for (int a = 0; a < 32; a++) begin
            cfg_write(a, a);
        end
        bus.cfg_commit_i = 1'b1;
        step();
        bus.cfg_commit_i = 1'b0;
        m_swap();
        chk("t3_cfgrdy", DW'(bus.cfg_ready_o), DW'(1));
        for (int i = 0; i < L; i++) begin
            d[i*W +: W] = W'(i % 32);
        end
        send("t3", d);
        wait_out("t3", 0, d, 0);

        d = rand_block();
        e = expect_of(d);
        send("t4", d);
        step();
        bus.cfg_commit_i = 1'b1;
        step();
        bus.cfg_commit_i = 1'b0;
        chk("t4_pend", DW'(bus.cfg_ready_o), DW'(0));
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = 5'd5;
        bus.cfg_wdata_i = 5'd0;
        step();
        bus.cfg_we_i = 1'b0;
        chk("t4_pend2", DW'(bus.cfg_ready_o), DW'(0));
        chk("t4_drop", DW'(bus.cfg_rdata_o), DW'(m_sh[5]));
        wait_out("t4", 3, e, 0);
        chk("t4_pend3", DW'(bus.cfg_ready_o), DW'(0));
        step();
        m_swap();
        chk("t4_swapped", DW'(bus.cfg_ready_o), DW'(1));
        cfg_read("t4_rb", 5);
        d = rand_block();
        send("t4b", d);
        wait_out("t4b", 0, expect_of(d), 1);

        cfg_write(3, 'h1a);
        cfg_read("t5_rb", 3);
        d = rand_block();
        send("t5", d);
        wait_out("t5", 0, expect_of(d), 0);

        bus.cfg_we_i     = 1'b1;
        bus.cfg_addr_i   = 5'd0;
        bus.cfg_wdata_i  = 5'h1f;
        bus.cfg_commit_i = 1'b1;
        step();
        bus.cfg_we_i     = 1'b0;
        bus.cfg_commit_i = 1'b0;
        m_sh[0] = 'h1f;
        m_swap();
        send("t5b", '0);
        wait_out("t5b", 0, k1f, 0);

        d = rand_block();
        send("t6", d);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_reset();
        for (int c = 0; c < 6; c++) begin
            chk("t6_noval", DW'(bus.out_valid_o), DW'(0));
            step();
        end
        chk("t6_irdy", DW'(bus.in_ready_o), DW'(1));
        cfg_read("t6_rb", 3);
        d = rand_block();
        send("t6b", d);
        wait_out("t6b", 0, expect_of(d), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
